// File: rtl/asi_pkg.sv
// Shared types for the ASI user-memory arbiter: FSM state encoding, the
// tagged read-pipe entry, and a one-hot to index helper.
package asi_pkg;

    // Widest supported requester count and the matching index width.
    localparam int ASI_NM_MAX = 16;
    localparam int ASI_IDXW   = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } TYPE_ARB_ST;

    // One slot of the read-return pipe: a read is in flight and who issued it.
    typedef struct packed {
        logic                vld;
        logic [ASI_IDXW-1:0] idx;
    } rd_ent_t;

    // Index of the set bit in a one-hot vector (0 when no bit is set).
    function automatic logic [ASI_IDXW-1:0] oh2idx(input logic [ASI_NM_MAX-1:0] oh);
        logic [ASI_IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < ASI_NM_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | ASI_IDXW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/asi_rr_pick.sv
// Combinational round-robin picker. Searches req starting just after ptr and
// wrapping modulo N, so the requester at ptr has the lowest priority.
module asi_rr_pick #(
    parameter int N  = 4,
    parameter int NW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          found
);

    logic [NW-1:0] idx;

    // First set request in rotating order ptr+1, ptr+2, ..., ptr.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = NW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/asi_usr_arb.sv
// Burst-granular round-robin arbiter sharing one single-port user memory
// between ASI_NM requesters. Read data returns through a tagged pipe that
// matches the slave latency, so pulses stay with the requester that issued
// them even after the grant has moved on.
// Optional build macro: ASI_ARB_STAT_EN adds per-requester grant and
// wait-cycle counters on arb_gnt_cnt / arb_wait_cnt.
//
// state    | meaning
// ARB_IDLE | no grant held; pick a winner from m_req
// ARB_BUSY | m_gnt holds the current burst owner until its last access
module asi_usr_arb
    import asi_pkg::*;
#(
    parameter int ASI_NM     = 4,
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 40,
    parameter int AXI_WSTRBW = AXI_DW / 8,
    parameter int SLV_WS     = 1,
    parameter int ASI_NMW    = $clog2(ASI_NM)
) (
    input  logic                         usr_clk,
    input  logic                         usr_reset_n,
    input  logic [ASI_NM-1:0]            m_req,
    output logic [ASI_NM-1:0]            m_gnt,
    input  logic [ASI_NM-1:0]            m_ce,
    input  logic [ASI_NM-1:0]            m_last,
    input  logic [ASI_NM*AXI_AW-1:0]     m_a,
    input  logic [ASI_NM*AXI_DW-1:0]     m_d,
    input  logic [ASI_NM*AXI_WSTRBW-1:0] m_we,
    output logic [AXI_DW-1:0]            m_q,
    output logic [ASI_NM-1:0]            m_qvalid,
    output logic [AXI_AW-1:0]            usr_a,
    output logic                         usr_ce,
    output logic [AXI_DW-1:0]            usr_d,
    output logic [AXI_WSTRBW-1:0]        usr_we,
    input  logic [AXI_DW-1:0]            usr_q
`ifdef ASI_ARB_STAT_EN
    ,
    output logic [ASI_NM*32-1:0]         arb_gnt_cnt,
    output logic [ASI_NM*32-1:0]         arb_wait_cnt
`endif
);

    TYPE_ARB_ST         st_q, st_d;
    logic [ASI_NM-1:0]  gnt_q, gnt_d;
    logic [ASI_NMW-1:0] gidx_q, gidx_d;
    logic [ASI_NMW-1:0] ptr_q, ptr_d;

    rd_ent_t            pipe_q [SLV_WS];
    rd_ent_t            pipe_d [SLV_WS];
    rd_ent_t            pipe_out;

    logic [ASI_NM-1:0]  pick_gnt;
    logic               pick_found;
    logic [ASI_NMW-1:0] pick_idx;
    logic [ASI_NMW-1:0] pick_ptr;
    logic               eob;
    logic               rd_push;

    // While busy the picker searches with the current owner at lowest
    // priority, which is exactly the end-of-burst handover rule; when idle it
    // uses the stored pointer. One picker serves both paths.
    assign pick_ptr = (st_q == ARB_BUSY) ? gidx_q : ptr_q;

    asi_rr_pick #(
        .N  (ASI_NM),
        .NW (ASI_NMW)
    ) u_pick (
        .req   (m_req),
        .ptr   (pick_ptr),
        .gnt   (pick_gnt),
        .found (pick_found)
    );

    assign pick_idx = ASI_NMW'(oh2idx(ASI_NM_MAX'(pick_gnt)));
    assign eob      = (st_q == ARB_BUSY) && m_ce[gidx_q] && m_last[gidx_q];

    // Slave port is a straight mux of the owner; strobes only while busy.
    always_comb begin
        usr_ce = (st_q == ARB_BUSY) && m_ce[gidx_q];
        usr_a  = m_a[int'(gidx_q)*AXI_AW +: AXI_AW];
        usr_d  = m_d[int'(gidx_q)*AXI_DW +: AXI_DW];
        usr_we = usr_ce ? m_we[int'(gidx_q)*AXI_WSTRBW +: AXI_WSTRBW] : '0;
    end

    assign rd_push = usr_ce && !(|usr_we);
    assign m_gnt   = gnt_q;

    // Next grant, owner index, pointer and state.
    always_comb begin
        st_d   = st_q;
        gnt_d  = gnt_q;
        gidx_d = gidx_q;
        ptr_d  = ptr_q;
        case (st_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_d  = pick_gnt;
                    gidx_d = pick_idx;
                    st_d   = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (eob) begin
                    ptr_d = gidx_q;
                    if (pick_found) begin
                        gnt_d  = pick_gnt;
                        gidx_d = pick_idx;
                    end else begin
                        gnt_d = '0;
                        st_d  = ARB_IDLE;
                    end
                end
            end
            default: begin
                gnt_d = '0;
                st_d  = ARB_IDLE;
            end
        endcase
    end

    // Arbitration registers; pointer resets to the top so requester 0 wins first.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            st_q   <= ARB_IDLE;
            gnt_q  <= '0;
            gidx_q <= '0;
            ptr_q  <= ASI_NMW'(ASI_NM - 1);
        end else begin
            st_q   <= st_d;
            gnt_q  <= gnt_d;
            gidx_q <= gidx_d;
            ptr_q  <= ptr_d;
        end
    end

    // Read-return pipe: each read enters tagged with its issuer and shifts
    // one slot per cycle regardless of later grant changes.
    always_comb begin
        pipe_d[0] = {rd_push, ASI_IDXW'(gidx_q)};
        for (int i = 1; i < SLV_WS; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipe storage; async reset discards reads in flight.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            for (int i = 0; i < SLV_WS; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q <= pipe_d;
        end
    end

    // Pipe output steers the slave data strobe to the tagged requester.
    always_comb begin
        pipe_out = pipe_q[SLV_WS-1];
        m_qvalid = '0;
        for (int i = 0; i < ASI_NM; i++) begin
            m_qvalid[i] = pipe_out.vld && (pipe_out.idx == ASI_IDXW'(i));
        end
    end

    assign m_q = usr_q;

`ifdef ASI_ARB_STAT_EN
    logic [31:0] gcnt_q [ASI_NM];
    logic [31:0] gcnt_d [ASI_NM];
    logic [31:0] wcnt_q [ASI_NM];
    logic [31:0] wcnt_d [ASI_NM];
    logic        gload;

    // A grant event is any cycle where the grant register loads a winner.
    assign gload = pick_found && ((st_q == ARB_IDLE) || eob);

    // Saturating event counters.
    always_comb begin
        gcnt_d = gcnt_q;
        wcnt_d = wcnt_q;
        for (int i = 0; i < ASI_NM; i++) begin
            if (gload && pick_gnt[i] && (gcnt_q[i] != 32'hFFFF_FFFF)) begin
                gcnt_d[i] = gcnt_q[i] + 32'd1;
            end
            if (m_req[i] && !gnt_q[i] && (wcnt_q[i] != 32'hFFFF_FFFF)) begin
                wcnt_d[i] = wcnt_q[i] + 32'd1;
            end
        end
    end

    // Counter storage.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            for (int i = 0; i < ASI_NM; i++) begin
                gcnt_q[i] <= '0;
                wcnt_q[i] <= '0;
            end
        end else begin
            gcnt_q <= gcnt_d;
            wcnt_q <= wcnt_d;
        end
    end

    for (genvar gi = 0; gi < ASI_NM; gi++) begin : g_stat
        assign arb_gnt_cnt[gi*32 +: 32]  = gcnt_q[gi];
        assign arb_wait_cnt[gi*32 +: 32] = wcnt_q[gi];
    end
`endif

endmodule

// File: tb/tb_asi_usr_arb.sv
// Testbench for asi_usr_arb. Two instances share all stimulus: one with a
// single-cycle slave and one with a three-cycle slave. Grant and slave-port
// behaviour is checked inline; read returns go through a per-instance queue
// of expected {cycle, tag, data} consumed by an independent monitor.
module tb_asi_usr_arb;

    localparam int NM = 4;
    localparam int DW = 128;
    localparam int AW = 40;
    localparam int SW = DW / 8;

    typedef struct {
        int             cyc;
        logic [NM-1:0]  oh;
        logic [DW-1:0]  dat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NM-1:0]        m_req = '0;
    logic [NM-1:0]        m_ce = '0;
    logic [NM-1:0]        m_last = '0;
    logic [NM*AW-1:0]     m_a = '0;
    logic [NM*DW-1:0]     m_d = '0;
    logic [NM*SW-1:0]     m_we = '0;

    logic [NM-1:0]        gnt [2];
    logic [NM-1:0]        qv  [2];
    logic [DW-1:0]        mq  [2];
    logic [AW-1:0]        ua  [2];
    logic                 uce [2];
    logic [DW-1:0]        ud  [2];
    logic [SW-1:0]        uwe [2];
    logic [DW-1:0]        uq  [2];

    logic [DW-1:0]        s1;
    logic [DW-1:0]        s3 [3];

    exp_t q_ws1[$];
    exp_t q_ws3[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    asi_usr_arb #(.ASI_NM(NM), .AXI_DW(DW), .AXI_AW(AW), .SLV_WS(1)) dut_ws1 (
        .usr_clk(clk), .usr_reset_n(rst_n),
        .m_req(m_req), .m_gnt(gnt[0]), .m_ce(m_ce), .m_last(m_last),
        .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_q(mq[0]), .m_qvalid(qv[0]),
        .usr_a(ua[0]), .usr_ce(uce[0]), .usr_d(ud[0]), .usr_we(uwe[0]), .usr_q(uq[0])
    );

    asi_usr_arb #(.ASI_NM(NM), .AXI_DW(DW), .AXI_AW(AW), .SLV_WS(3)) dut_ws3 (
        .usr_clk(clk), .usr_reset_n(rst_n),
        .m_req(m_req), .m_gnt(gnt[1]), .m_ce(m_ce), .m_last(m_last),
        .m_a(m_a), .m_d(m_d), .m_we(m_we), .m_q(mq[1]), .m_qvalid(qv[1]),
        .usr_a(ua[1]), .usr_ce(uce[1]), .usr_d(ud[1]), .usr_we(uwe[1]), .usr_q(uq[1])
    );

    // Slave memory model: read data is a fixed function of the address.
    function automatic logic [DW-1:0] sdat(input logic [AW-1:0] a);
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0], a[31:0] + 32'd7, 32'hC0DE_0000 | {24'd0, a[7:0]}};
    endfunction

    always @(posedge clk) begin
        s1    <= sdat(ua[0]);
        s3[0] <= sdat(ua[1]);
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end
    assign uq[0] = s1;
    assign uq[1] = s3[2];

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Read-return monitor: consumes expectations whenever a qvalid appears.
    always @(negedge clk) begin
        exp_t e;
        if (q_ws1.size() > 0 && q_ws1[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL ws1_missing_qvalid expected at cyc %0d tag %b, not observed", q_ws1[0].cyc, q_ws1[0].oh);
            void'(q_ws1.pop_front());
        end
        if (q_ws3.size() > 0 && q_ws3[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL ws3_missing_qvalid expected at cyc %0d tag %b, not observed", q_ws3[0].cyc, q_ws3[0].oh);
            void'(q_ws3.pop_front());
        end
        if (qv[0] !== '0) begin
            if (q_ws1.size() == 0) begin
                checks++; errors++;
                $display("FAIL ws1_unexpected_qvalid at cyc %0d: got %b expected none", cyc, qv[0]);
            end else begin
                e = q_ws1.pop_front();
                chk("ws1_qvalid_tag", qv[0], e.oh);
                chk("ws1_q_data", mq[0], e.dat);
                chk("ws1_qvalid_cyc", cyc, e.cyc);
            end
        end
        if (qv[1] !== '0) begin
            if (q_ws3.size() == 0) begin
                checks++; errors++;
                $display("FAIL ws3_unexpected_qvalid at cyc %0d: got %b expected none", cyc, qv[1]);
            end else begin
                e = q_ws3.pop_front();
                chk("ws3_qvalid_tag", qv[1], e.oh);
                chk("ws3_q_data", mq[1], e.dat);
                chk("ws3_qvalid_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle with no access strobes; checks the grant both instances hold.
    task automatic idle_cyc(input logic [NM-1:0] req_v, input logic [NM-1:0] exp_gnt);
        m_req  = req_v;
        m_ce   = '0;
        m_last = '0;
        @(negedge clk);
        chk("idle_gnt_ws1", gnt[0], exp_gnt);
        chk("idle_gnt_ws3", gnt[1], exp_gnt);
        chk("idle_usr_ce", uce[0], 1'b0);
        step();
    endtask

    // One access by requester r, who must be the current owner.
    task automatic beat(input int r, input logic [AW-1:0] a, input bit wr, input bit last,
                        input logic [NM-1:0] req_v);
        logic [DW-1:0] d;
        logic [NM-1:0] oh;
        d  = {4{a[31:0]}} ^ 128'h0F0F_0000_0000_0000_0000_0000_0000_1234;
        oh = '0;
        oh[r] = 1'b1;
        m_req  = req_v;
        m_ce   = '0;
        m_last = '0;
        m_ce[r]   = 1'b1;
        m_last[r] = last;
        m_a[r*AW +: AW] = a;
        m_d[r*DW +: DW] = d;
        m_we[r*SW +: SW] = wr ? {SW{1'b1}} : {SW{1'b0}};
        if (!wr) begin
            q_ws1.push_back('{cyc + 1, oh, sdat(a)});
            q_ws3.push_back('{cyc + 3, oh, sdat(a)});
        end
        @(negedge clk);
        chk("beat_gnt_ws1", gnt[0], oh);
        chk("beat_gnt_ws3", gnt[1], oh);
        chk("beat_usr_ce", uce[0], 1'b1);
        chk("beat_usr_a", ua[0], a);
        chk("beat_usr_we", uwe[0], wr ? {SW{1'b1}} : {SW{1'b0}});
        if (wr) chk("beat_usr_d", ud[0], d);
        step();
        m_ce   = '0;
        m_last = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state.
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_gnt_ws1", gnt[0], 4'b0000);
        chk("rst_gnt_ws3", gnt[1], 4'b0000);
        chk("rst_qvalid_ws1", qv[0], 4'b0000);
        chk("rst_qvalid_ws3", qv[1], 4'b0000);
        chk("rst_usr_ce", uce[0], 1'b0);
        step();

        // All request at release: 0 first, then rotation 1, 2, 3, 0.
        m_req = 4'b1111;
        rst_n = 1'b1;
        idle_cyc(4'b1111, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            beat(k, 40'h1000 + 40'(k * 16), 1'b0, 1'b1, 4'b1111);
        end
        beat(0, 40'h1040, 1'b0, 1'b1, 4'b0000);
        idle_cyc(4'b0000, 4'b0000);

        // Requester 2, 4-beat read burst.
        idle_cyc(4'b0100, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            beat(2, 40'h100 + 40'(i * 16), 1'b0, i == 3, (i == 3) ? 4'b0000 : 4'b0100);
        end
        idle_cyc(4'b0000, 4'b0000);
        idle_cyc(4'b0000, 4'b0000);

        // Requester 0 writes while 1 waits; non-owner strobe is ignored;
        // handover to 1 with no idle cycle.
        idle_cyc(4'b0011, 4'b0000);
        beat(0, 40'h200, 1'b1, 1'b0, 4'b0011);
        m_ce[1] = 1'b1;
        m_we[1*SW +: SW] = {SW{1'b1}};
        m_a[1*AW +: AW] = 40'h999;
        @(negedge clk);
        chk("nonowner_usr_ce", uce[0], 1'b0);
        chk("nonowner_usr_we", uwe[0], {SW{1'b0}});
        chk("nonowner_gnt", gnt[0], 4'b0001);
        step();
        m_ce = '0;
        beat(0, 40'h210, 1'b1, 1'b0, 4'b0011);
        beat(0, 40'h220, 1'b1, 1'b1, 4'b0010);
        beat(1, 40'h230, 1'b0, 1'b1, 4'b0000);
        idle_cyc(4'b0000, 4'b0000);

        // Requester 1 reads, 3 takes over immediately; 1's late returns keep its tag.
        idle_cyc(4'b0010, 4'b0000);
        beat(1, 40'h300, 1'b0, 1'b0, 4'b1010);
        beat(1, 40'h310, 1'b0, 1'b1, 4'b1000);
        beat(3, 40'h400, 1'b0, 1'b0, 4'b1000);
        beat(3, 40'h410, 1'b0, 1'b1, 4'b0000);
        repeat (4) idle_cyc(4'b0000, 4'b0000);

        // Owner pauses 5 cycles and drops req without last: grant is held.
        idle_cyc(4'b0101, 4'b0000);
        beat(0, 40'h500, 1'b0, 1'b0, 4'b0101);
        repeat (5) idle_cyc(4'b0100, 4'b0001);
        beat(0, 40'h510, 1'b0, 1'b1, 4'b0100);
        beat(2, 40'h600, 1'b1, 1'b1, 4'b0000);
        repeat (3) idle_cyc(4'b0000, 4'b0000);

        // Reset with reads in flight; requester 0 regains priority afterwards.
        idle_cyc(4'b1000, 4'b0000);
        beat(3, 40'h700, 1'b0, 1'b0, 4'b1000);
        beat(3, 40'h710, 1'b0, 1'b0, 4'b1000);
        rst_n = 1'b0;
        q_ws1.delete();
        q_ws3.delete();
        m_req = 4'b1001;
        #1;
        chk("midrst_gnt_ws1", gnt[0], 4'b0000);
        chk("midrst_gnt_ws3", gnt[1], 4'b0000);
        chk("midrst_qvalid_ws1", qv[0], 4'b0000);
        chk("midrst_qvalid_ws3", qv[1], 4'b0000);
        repeat (2) step();
        rst_n = 1'b1;
        idle_cyc(4'b1001, 4'b0000);
        beat(0, 40'h800, 1'b0, 1'b1, 4'b1000);
        beat(3, 40'h810, 1'b0, 1'b1, 4'b0000);
        repeat (5) idle_cyc(4'b0000, 4'b0000);

        chk("ws1_pending_reads", q_ws1.size(), 0);
        chk("ws3_pending_reads", q_ws3.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
